// File: rtl/sync_g_fifo.sv
//==============================================================================
// Module      : sync_g_fifo
// Description : Single-clock FIFO with registered read data, occupancy count,
//               almost-full/almost-empty flags and optional sticky error flags
//               (enabled by defining SYNC_G_FIFO_ERR_EN).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sync_g_fifo #(
  parameter int DATA_W   = 4,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              wr_req_,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req_,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  input  logic              clr_err_,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] c_DEPTH    = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] c_AF_LEVEL = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] c_AE_LEVEL = AE_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] c_ONE      = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              w_wr_ok;
  logic              w_rd_ok;

  // Flags come from the count register alone, so acceptance never looks at
  // same-cycle requests from the other side.
  assign full         = (count_q == c_DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= c_AF_LEVEL);
  assign almost_empty = (count_q <= c_AE_LEVEL);

  assign w_wr_ok = !wr_req_ && !full;
  assign w_rd_ok = !rd_req_ && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = w_rd_ok;
    if (w_wr_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (w_rd_ok) begin
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({w_wr_ok, w_rd_ok})
      2'b10:   count_d = count_q + c_ONE;
      2'b01:   count_d = count_q - c_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;

`ifdef SYNC_G_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Set takes priority over a simultaneous clear.
  always_comb begin
    overflow_d  = (!wr_req_ && full)  || (overflow_q  && clr_err_);
    underflow_d = (!rd_req_ && empty) || (underflow_q && clr_err_);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic w_unused_clr_err;
  assign w_unused_clr_err = clr_err_;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_g_fifo.sv
//==============================================================================
// Module      : tb_sync_g_fifo
// Description : Self-checking bench for sync_g_fifo against a queue model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sync_g_fifo;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 16;
`ifdef SYNC_G_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_ = 1'b0;
  logic              wr_req_ = 1'b1;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_req_ = 1'b1;
  logic              clr_err_ = 1'b1;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, full, empty, almost_full, almost_empty;
  logic [4:0]        count;
  logic              overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] q[$];
  bit                m_valid;
  logic [DATA_W-1:0] m_data;
  bit                m_ovf, m_unf;

  sync_g_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(DEPTH-2), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_(rst_), .wr_req_(wr_req_), .wr_data(wr_data), .rd_req_(rd_req_),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .clr_err_(clr_err_), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] obs_vec();
    return {count, full, empty, almost_full, almost_empty, rd_valid, rd_data, overflow, underflow};
  endfunction

  function automatic logic [15:0] exp_vec();
    int n = q.size();
    return {5'(n), n == DEPTH, n == 0, n >= DEPTH-2, n <= 2, m_valid, m_data, m_ovf, m_unf};
  endfunction

  function automatic void model_reset();
    q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endfunction

  // Drives one clock of requests and advances the model; checks are done by callers.
  task automatic drive(input bit wr, input logic [DATA_W-1:0] wd, input bit rd, input bit clr);
    bit was_full, was_empty;
    @(negedge clk);
    wr_req_  = ~wr;
    wr_data  = wd;
    rd_req_  = ~rd;
    clr_err_ = ~clr;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (ERR_EN) begin
      m_ovf = (wr && was_full)  || (m_ovf && !clr);
      m_unf = (rd && was_empty) || (m_unf && !clr);
    end
    m_valid = rd && !was_empty;
    if (m_valid) m_data = q.pop_front();
    if (wr && !was_full) q.push_back(wd);
    @(posedge clk);
    #1;
    wr_req_  = 1'b1;
    rd_req_  = 1'b1;
    clr_err_ = 1'b1;
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_vec: got %h want %h", obs_vec(), exp_vec());
    end
    n_tests++;
    if ({empty, almost_empty, count, rd_valid, rd_data} !== {1'b1, 1'b1, 5'd0, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_vals: got e=%b ae=%b cnt=%0d v=%b d=%h", empty, almost_empty, count, rd_valid, rd_data);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_idle: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b0);
      n_tests++;
      if ({count, almost_full, full} !== {5'(i+1), (i+1) >= 14, (i+1) == 16} || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL fill[%0d]: got cnt=%0d af=%b f=%b vec=%h want vec=%h", i, count, almost_full, full, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n_tests++;
      if (rd_valid !== 1'b1 || rd_data !== 4'(i) || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL drain[%0d]: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, 4'(i));
      end
    end
    n_tests++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL drain_empty: got e=%b cnt=%0d want e=1 cnt=0", empty, count);
    end
  endtask

  task automatic test_wrap();
    int lens[4] = '{10, 10, 16, 16};
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < lens[p]; i++) begin
        drive(p % 2 == 0, 4'($urandom), p % 2 == 1, 1'b0);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL wrap[%0d.%0d]: got %h want %h", p, i, obs_vec(), exp_vec());
        end
      end
    end
    n_tests++;
    if (count !== 5'd0) begin
      n_fail++;
      $display("FAIL wrap_end: got cnt=%0d want 0", count);
    end
  endtask

  task automatic test_simultaneous();
    logic [DATA_W-1:0] oldest;
    while (q.size() < DEPTH) drive(1'b1, 4'($urandom), 1'b0, 1'b0);
    oldest = q[0];
    drive(1'b1, 4'hA, 1'b1, 1'b0);
    n_tests++;
    if (rd_valid !== 1'b1 || rd_data !== oldest || count !== 5'd15 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL full_wr_rd: got v=%b d=%h cnt=%0d want v=1 d=%h cnt=15", rd_valid, rd_data, count, oldest);
    end
    while (q.size() > 0) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL full_drain: got %h want %h", obs_vec(), exp_vec());
      end
    end
    drive(1'b1, 4'h5, 1'b1, 1'b0);
    n_tests++;
    if (rd_valid !== 1'b0 || count !== 5'd1) begin
      n_fail++;
      $display("FAIL empty_wr_rd: got v=%b cnt=%0d want v=0 cnt=1", rd_valid, count);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    n_tests++;
    if (rd_valid !== 1'b1 || rd_data !== 4'h5 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL empty_followup: got v=%b d=%h cnt=%0d want v=1 d=5 cnt=0", rd_valid, rd_data, count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) drive(1'b1, 4'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'($urandom), 1'b1, 1'b0);
      n_tests++;
      if (count !== 5'd5 || rd_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    while (q.size() > 0) drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_errors();
    while (q.size() < DEPTH) drive(1'b1, 4'($urandom), 1'b0, 1'b0);
    drive(1'b1, 4'h3, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    n_tests++;
    if (overflow !== ERR_EN || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow: got ovf=%b unf=%b want ovf=%b unf=0", overflow, underflow, ERR_EN);
    end
    while (q.size() > 0) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    n_tests++;
    if (overflow !== ERR_EN || underflow !== ERR_EN) begin
      n_fail++;
      $display("FAIL underflow: got ovf=%b unf=%b want both=%b", overflow, underflow, ERR_EN);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    n_tests++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_err: got ovf=%b unf=%b want 0 0", overflow, underflow);
    end
    drive(1'b0, '0, 1'b1, 1'b1);
    n_tests++;
    if (underflow !== ERR_EN || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL set_wins: got unf=%b want %b", underflow, ERR_EN);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int pw;
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) pw = (i / 60) % 3 == 0 ? 80 : ((i / 60) % 3 == 1 ? 20 : 50);
      drive($urandom_range(0, 99) < pw, 4'($urandom), $urandom_range(0, 99) < (100 - pw),
            $urandom_range(0, 19) == 0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    while (q.size() > 0) drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 4'($urandom), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    rd_req_ = 1'b0;
    #2;
    rst_ = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({count, rd_valid, rd_data, empty} !== {5'd0, 1'b0, 4'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid: got cnt=%0d v=%b d=%h e=%b want cnt=0 v=0 d=0 e=1", count, rd_valid, rd_data, empty);
    end
    @(negedge clk);
    rd_req_ = 1'b1;
    rst_    = 1'b1;
    drive(1'b1, 4'h9, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    n_tests++;
    if (rd_valid !== 1'b1 || rd_data !== 4'h9 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid_after: got v=%b d=%h cnt=%0d want v=1 d=9 cnt=0", rd_valid, rd_data, count);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_back_to_back();
    test_errors();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
